cluster_periph_router: RTL and testbench
========================================

# cluster_periph_router

Routes the cluster peripheral-interconnect request stream onto the numbered peripheral slave ports: EOC 0, timer 1, event unit 2, HWPE 4/5/7, icache ctrl 8, DMA 9, ext 10. It sits directly upstream of those slave ports. For each request it decodes the slave ID from the address and tracks outstanding transactions so responses return to the master in order. Unmapped IDs are answered locally with an error response.

## Interface
- NB_SPERIPH, 11, number of slave ports (IDs 0..10)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- ID_WIDTH, 5, transaction ID width
- MAX_OUTSTANDING, 4, outstanding-transaction limit (power of two, at least 2)
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- mst_req_i / mst_gnt_o  in/out  1  master request / grant
- mst_add_i  in  ADDR_WIDTH  address; bits [13:10] = slave ID
- mst_wen_i  in  1  0 = write, 1 = read
- mst_wdata_i, mst_be_i, mst_id_i  in  DW, DW/8, ID_WIDTH  write data, byte enables, transaction ID
- mst_r_valid_o, mst_r_opc_o  out  1  response valid / error flag
- mst_r_rdata_o, mst_r_id_o  out  DW, ID_WIDTH  response data / ID
- slv_req_o / slv_gnt_i  out/in  NB_SPERIPH  per-slave request / grant
- slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_id_o  out  as master  broadcast request fields
- slv_r_valid_i, slv_r_opc_i  in  NB_SPERIPH  per-slave response valid / error
- slv_r_rdata_i, slv_r_id_i  in  NB_SPERIPH×DW, NB_SPERIPH×ID_WIDTH  per-slave response data / ID, flattened

## Operation
- Decode: tgt = mst_add_i[13:10]. IDs 0,1,2,4,5,7,8,9,10 are mapped. IDs 3, 6 and 11..15 are unmapped.
- Request path is combinational:
  - slv_req_o[tgt] = mst_req_i & ~stall.
  - mst_gnt_o = slv_gnt_i[tgt] & ~stall.
  - Broadcast fields pass through.
- State: cnt (0..MAX_OUTSTANDING), lock_tgt (4 bits), err_pend (1 bit), err_id (ID_WIDTH).
- stall is asserted when either condition holds:
  - cnt == MAX_OUTSTANDING;
  - cnt != 0 and tgt != lock_tgt.
- Accepted request: on mst_req_i & mst_gnt_o, cnt increments and lock_tgt <= tgt.
- Completed response: on mst_r_valid_o, cnt decrements. A simultaneous accept and complete leaves cnt unchanged.
- Response mux: forwards slv_r_* of lock_tgt while cnt != 0. slv_r_valid_i of non-lock slaves is ignored.
- Error path: an unmapped request is granted internally; no slv_req_o is raised.
  - The next cycle: mst_r_valid_o = 1, mst_r_opc_o = 1, mst_r_rdata_o = 32'hBADA_CCE5, mst_r_id_o = captured mst_id_i.
  - The ERR target is encoded as lock_tgt = 4'hF.
- Reset: cnt = 0, lock_tgt = 0, err_pend = 0, err_id = 0. All outputs are 0 with mst_req_i low.
- Reset mid-operation drops in-flight responses. Slave responses arriving after reset are ignored because cnt = 0.

## Timing
- Request: zero-cycle path from request to grant.
- Slave responses: any latency of 1 cycle or more. The response mux is combinational.
- Error responses: exactly 1 cycle after the grant.
- Back-to-back requests to the same target are granted every cycle until cnt reaches MAX_OUTSTANDING.
- Switching target stalls until the last response of the old target completes. The new grant can occur in the same cycle as that final response, since stall uses cnt before the update only when the response is not valid.
- mst_r_valid_o is asserted for at most one cycle per transaction. There is no back-pressure on responses.

## Configuration
- PERIPH_ROUTER_ERR_RESP_EN defined: unmapped IDs get the local error response described above.
- Not defined:
  - Unmapped IDs are routed to slave 10 (ext) as ordinary traffic.
  - The err_pend/err_id logic is not generated.
  - mst_r_opc_o comes from the slave only.

## Structure
- Slave ID constants live in the shared cluster package: 0 EOC, 1 timer, 2 event unit, 4/5/7 HWPE, 8 icache ctrl, 9 DMA, 10 ext.
- Also add to the package: a localparam mapped-ID mask 11'b111_1011_0111, the error data constant, and the ERR encoding 4'hF.
- One sub-module, periph_router_decode: combinational address-to-target decode plus mapped flag, reusable by the cluster alias logic.

## Test plan
- Read to addr 0x0000_0400 (timer, ID 1); slave grants and responds 2 cycles later with 0x1234 → slv_req_o[1] = 1, master sees rdata 0x1234, opc 0, matching ID, cnt back to 0.
- Four reads to the DMA (ID 9) with no responses → first four granted; the fifth has mst_gnt_o = 0 until one response returns.
- Write to the EOC (ID 0) with a response pending, then a request to the event unit (ID 2) → the ID 2 request stalls; it is granted in the cycle the EOC response arrives, or later.
- Read to addr 0x0000_0C00 (ID 3) with the macro → no slv_req_o; the next cycle gives r_valid, opc 1, rdata 0xBADACCE5. Without the macro → slv_req_o[10] = 1.
- Simultaneous accept and complete on the same target → cnt unchanged; continuous streaming for 20 transactions sustains 1 transaction per cycle.
- rst_i asserted with cnt = 3 → next cycle cnt = 0 and all outputs 0; late slave r_valid is not forwarded.

Source files
------------

// File: rtl/cluster_periph_router_pkg.sv
// Shared cluster peripheral constants: slave port IDs, mapped-ID mask and the local error response.
// Used by cluster_periph_router and periph_router_decode (optional macro: PERIPH_ROUTER_ERR_RESP_EN).
package cluster_periph_router_pkg;

   localparam logic [3:0]  SPER_EOC_ID        = 4'd0;
   localparam logic [3:0]  SPER_TIMER_ID      = 4'd1;
   localparam logic [3:0]  SPER_EVENT_ID      = 4'd2;
   localparam logic [3:0]  SPER_HWPE0_ID      = 4'd4;
   localparam logic [3:0]  SPER_HWPE1_ID      = 4'd5;
   localparam logic [3:0]  SPER_HWPE2_ID      = 4'd7;
   localparam logic [3:0]  SPER_ICACHE_CTRL_ID = 4'd8;
   localparam logic [3:0]  SPER_DMA_ID        = 4'd9;
   localparam logic [3:0]  SPER_EXT_ID        = 4'd10;

   // Bit i set means slave ID i exists.
   localparam logic [10:0] SPER_MAPPED_MASK   = 11'b111_1011_0111;
   localparam logic [31:0] SPER_ERR_RDATA     = 32'hBADA_CCE5;
   localparam logic [3:0]  SPER_ERR_TGT       = 4'hF;

   function automatic logic sper_is_mapped(input logic [3:0] id_i);
      logic mapped;
      if (id_i < 4'd11) begin
         mapped = SPER_MAPPED_MASK[id_i];
      end else begin
         mapped = 1'b0;
      end
      return mapped;
   endfunction

endpackage

// File: rtl/periph_router_decode.sv
// Address-to-slave decode for the cluster peripheral space: slave ID from address bits [13:10]
// plus a flag telling whether that ID has a real slave behind it.
module periph_router_decode
   import cluster_periph_router_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] add_i,
   output logic [3:0]            tgt_o,
   output logic                  mapped_o
);

   logic unused_add_bits;

   // Only the slave-select field matters; everything else is offset inside the slave.
   always_comb begin
      tgt_o    = add_i[13:10];
      mapped_o = sper_is_mapped(add_i[13:10]);
   end

   assign unused_add_bits = ^{add_i[ADDR_WIDTH-1:14], add_i[9:0]};

endmodule

// File: rtl/cluster_periph_router.sv
// Cluster peripheral router: steers master requests to one slave port and returns responses in order.
// PERIPH_ROUTER_ERR_RESP_EN: unmapped IDs are answered locally with an error instead of going to ext.
module cluster_periph_router
   import cluster_periph_router_pkg::*;
#(
   parameter int unsigned NB_SPERIPH      = 11,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ID_WIDTH        = 5,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             mst_req_i,
   output logic                             mst_gnt_o,
   input  logic [ADDR_WIDTH-1:0]            mst_add_i,
   input  logic                             mst_wen_i,
   input  logic [DATA_WIDTH-1:0]            mst_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]          mst_be_i,
   input  logic [ID_WIDTH-1:0]              mst_id_i,
   output logic                             mst_r_valid_o,
   output logic                             mst_r_opc_o,
   output logic [DATA_WIDTH-1:0]            mst_r_rdata_o,
   output logic [ID_WIDTH-1:0]              mst_r_id_o,
   output logic [NB_SPERIPH-1:0]            slv_req_o,
   input  logic [NB_SPERIPH-1:0]            slv_gnt_i,
   output logic [ADDR_WIDTH-1:0]            slv_add_o,
   output logic                             slv_wen_o,
   output logic [DATA_WIDTH-1:0]            slv_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          slv_be_o,
   output logic [ID_WIDTH-1:0]              slv_id_o,
   input  logic [NB_SPERIPH-1:0]            slv_r_valid_i,
   input  logic [NB_SPERIPH-1:0]            slv_r_opc_i,
   input  logic [NB_SPERIPH*DATA_WIDTH-1:0] slv_r_rdata_i,
   input  logic [NB_SPERIPH*ID_WIDTH-1:0]   slv_r_id_i
);

   localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_eff;
   logic [3:0]            lock_tgt_q, lock_tgt_d;
   logic [3:0]            dec_tgt, tgt;
   logic                  dec_mapped;
   logic                  stall, accept, complete, tgt_gnt;
   logic                  sel_valid, sel_opc;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic [ID_WIDTH-1:0]   sel_id;
`ifdef PERIPH_ROUTER_ERR_RESP_EN
   logic                  err_pend_q, err_pend_d;
   logic [ID_WIDTH-1:0]   err_id_q, err_id_d;
`endif

   periph_router_decode #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_decode (
      .add_i    (mst_add_i),
      .tgt_o    (dec_tgt),
      .mapped_o (dec_mapped)
   );

   // Effective target: unmapped IDs become the local error target or fall through to ext.
   always_comb begin
      if (dec_mapped) begin
         tgt = dec_tgt;
      end else begin
`ifdef PERIPH_ROUTER_ERR_RESP_EN
         tgt = SPER_ERR_TGT;
`else
         tgt = SPER_EXT_ID;
`endif
      end
   end

   // Per-port selects: grant of the requested port, response fields of the locked port.
   always_comb begin
      tgt_gnt   = 1'b0;
      sel_valid = 1'b0;
      sel_opc   = 1'b0;
      sel_rdata = '0;
      sel_id    = '0;
      for (int i = 0; i < int'(NB_SPERIPH); i++) begin
         tgt_gnt   = tgt_gnt | (slv_gnt_i[i] & (tgt == 4'(i)));
         sel_valid = sel_valid | (slv_r_valid_i[i] & (lock_tgt_q == 4'(i)));
         sel_opc   = sel_opc | (slv_r_opc_i[i] & (lock_tgt_q == 4'(i)));
         sel_rdata = sel_rdata | ({DATA_WIDTH{lock_tgt_q == 4'(i)}} & slv_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
         sel_id    = sel_id | ({ID_WIDTH{lock_tgt_q == 4'(i)}} & slv_r_id_i[i*ID_WIDTH +: ID_WIDTH]);
      end
   end

   // Response mux: only the locked target may answer, and only while something is outstanding.
   always_comb begin
      mst_r_valid_o = 1'b0;
      mst_r_opc_o   = 1'b0;
      mst_r_rdata_o = '0;
      mst_r_id_o    = '0;
      if (cnt_q != '0) begin
`ifdef PERIPH_ROUTER_ERR_RESP_EN
         if (lock_tgt_q == SPER_ERR_TGT) begin
            mst_r_valid_o = err_pend_q;
            mst_r_opc_o   = 1'b1;
            mst_r_rdata_o = DATA_WIDTH'(SPER_ERR_RDATA);
            mst_r_id_o    = err_id_q;
         end else begin
            mst_r_valid_o = sel_valid;
            mst_r_opc_o   = sel_opc;
            mst_r_rdata_o = sel_rdata;
            mst_r_id_o    = sel_id;
         end
`else
         mst_r_valid_o = sel_valid;
         mst_r_opc_o   = sel_opc;
         mst_r_rdata_o = sel_rdata;
         mst_r_id_o    = sel_id;
`endif
      end else begin
         mst_r_valid_o = 1'b0;
      end
   end

   // Stall on the count as it will be after this cycle's response, so a target switch
   // can be granted in the same cycle the last old response retires.
   always_comb begin
      cnt_eff = cnt_q - CNT_W'(mst_r_valid_o);
      stall   = (cnt_eff == CNT_MAX) | ((cnt_eff != '0) & (tgt != lock_tgt_q));
      if (tgt == SPER_ERR_TGT) begin
         mst_gnt_o = mst_req_i & ~stall;
      end else begin
         mst_gnt_o = tgt_gnt & ~stall;
      end
      slv_req_o = '0;
      for (int i = 0; i < int'(NB_SPERIPH); i++) begin
         slv_req_o[i] = mst_req_i & ~stall & (tgt == 4'(i));
      end
      accept   = mst_req_i & mst_gnt_o;
      complete = mst_r_valid_o;
   end

   // Request fields are broadcast to every slave; only slv_req_o selects one.
   always_comb begin
      slv_add_o   = mst_add_i;
      slv_wen_o   = mst_wen_i;
      slv_wdata_o = mst_wdata_i;
      slv_be_o    = mst_be_i;
      slv_id_o    = mst_id_i;
   end

   // Outstanding count and lock target next state.
   always_comb begin
      cnt_d = cnt_q;
      case ({accept, complete})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (accept) begin
         lock_tgt_d = tgt;
      end else begin
         lock_tgt_d = lock_tgt_q;
      end
   end

   // Outstanding-tracking registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         lock_tgt_q <= 4'h0;
      end else begin
         cnt_q      <= cnt_d;
         lock_tgt_q <= lock_tgt_d;
      end
   end

`ifdef PERIPH_ROUTER_ERR_RESP_EN
   // An error request is answered exactly one cycle after its grant.
   always_comb begin
      err_pend_d = accept & (tgt == SPER_ERR_TGT);
      if (err_pend_d) begin
         err_id_d = mst_id_i;
      end else begin
         err_id_d = err_id_q;
      end
   end

   // Local error response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_pend_q <= 1'b0;
         err_id_q   <= '0;
      end else begin
         err_pend_q <= err_pend_d;
         err_id_q   <= err_id_d;
      end
   end
`endif

endmodule

// File: tb/tb_cluster_periph_router.sv
// Self-checking bench for cluster_periph_router: directed scenarios plus a randomized run
// against an in-order outstanding-transaction queue model.
module tb_cluster_periph_router;

   localparam int NB = 11, AW = 32, DW = 32, IW = 5, MAXO = 4;
`ifdef PERIPH_ROUTER_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int            tgt;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic          opc;
      int            due;
   } txn_t;

   logic clk_i = 1'b0, rst_i;
   logic mst_req_i, mst_gnt_o, mst_wen_i, mst_r_valid_o, mst_r_opc_o, slv_wen_o;
   logic [AW-1:0] mst_add_i, slv_add_o;
   logic [DW-1:0] mst_wdata_i, mst_r_rdata_o, slv_wdata_o;
   logic [DW/8-1:0] mst_be_i, slv_be_o;
   logic [IW-1:0] mst_id_i, mst_r_id_o, slv_id_o;
   logic [NB-1:0] slv_req_o, slv_gnt_i, slv_r_valid_i, slv_r_opc_i;
   logic [NB*DW-1:0] slv_r_rdata_i;
   logic [NB*IW-1:0] slv_r_id_i;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk_i = ~clk_i;

   cluster_periph_router dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mst_req_i(mst_req_i), .mst_gnt_o(mst_gnt_o), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
      .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i), .mst_id_i(mst_id_i),
      .mst_r_valid_o(mst_r_valid_o), .mst_r_opc_o(mst_r_opc_o), .mst_r_rdata_o(mst_r_rdata_o),
      .mst_r_id_o(mst_r_id_o),
      .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
      .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o), .slv_id_o(slv_id_o),
      .slv_r_valid_i(slv_r_valid_i), .slv_r_opc_i(slv_r_opc_i), .slv_r_rdata_i(slv_r_rdata_i),
      .slv_r_id_i(slv_r_id_i)
   );

   function automatic bit is_mapped(input int t);
      return t inside {0, 1, 2, 4, 5, 7, 8, 9, 10};
   endfunction

   task automatic idle();
      mst_req_i = 1'b0; mst_add_i = '0; mst_wen_i = 1'b0; mst_wdata_i = '0; mst_be_i = '0; mst_id_i = '0;
      slv_gnt_i = '0; slv_r_valid_i = '0; slv_r_opc_i = '0; slv_r_rdata_i = '0; slv_r_id_i = '0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      idle();
   endtask

   task automatic drive_req(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic w);
      mst_req_i = 1'b1; mst_add_i = a; mst_id_i = i; mst_wen_i = w;
      mst_wdata_i = $urandom; mst_be_i = 4'hF;
   endtask

   task automatic slave_resp(input int s, input logic [DW-1:0] d, input logic [IW-1:0] i, input logic o);
      slv_r_valid_i[s] = 1'b1;
      slv_r_opc_i[s] = o;
      slv_r_rdata_i[s*DW +: DW] = d;
      slv_r_id_i[s*IW +: IW] = i;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_gnt_o, mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o, slv_req_o, slv_add_o,
           slv_wen_o, slv_wdata_o, slv_be_o, slv_id_o} !== '0) begin
         n_mis++; $display("FAIL reset_outputs: got gnt=%b rv=%b req=%h want all zero", mst_gnt_o, mst_r_valid_o, slv_req_o);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_single_read();
      step(); drive_req(32'h0000_0400, 5'd5, 1'b1); slv_gnt_i[1] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({slv_req_o, mst_gnt_o} !== {11'h002, 1'b1}) begin
         n_mis++; $display("FAIL timer_req: got req=%h gnt=%b want req=002 gnt=1", slv_req_o, mst_gnt_o);
      end
      n_cmp++;
      if ({slv_add_o, slv_wen_o, slv_id_o, slv_wdata_o} !== {32'h0000_0400, 1'b1, 5'd5, mst_wdata_i}) begin
         n_mis++; $display("FAIL broadcast: got add=%h wen=%b id=%h want add=400 wen=1 id=5", slv_add_o, slv_wen_o, slv_id_o);
      end
      step();
      @(negedge clk_i);
      n_cmp++;
      if (mst_r_valid_o !== 1'b0) begin
         n_mis++; $display("FAIL timer_early_rvalid: got %b want 0", mst_r_valid_o);
      end
      step(); slave_resp(1, 32'h1234, 5'd5, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 1'b0, 32'h1234, 5'd5}) begin
         n_mis++; $display("FAIL timer_resp: got v=%b opc=%b rdata=%h id=%h want 1 0 1234 05",
                           mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o);
      end
      step(); drive_req(32'h0000_0800, 5'd6, 1'b1); slv_gnt_i[2] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({slv_req_o, mst_gnt_o} !== {11'h004, 1'b1}) begin
         n_mis++; $display("FAIL timer_cnt_zero: got req=%h gnt=%b want req=004 gnt=1", slv_req_o, mst_gnt_o);
      end
      step(); slave_resp(2, 32'h55, 5'd6, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 32'h55, 5'd6}) begin
         n_mis++; $display("FAIL event_resp: got v=%b rdata=%h id=%h want 1 55 06", mst_r_valid_o, mst_r_rdata_o, mst_r_id_o);
      end
   endtask

   task automatic test_outstanding_limit();
      for (int k = 0; k < 4; k++) begin
         step(); drive_req(32'h0000_2400, 5'(k), 1'b1); slv_gnt_i[9] = 1'b1;
         @(negedge clk_i);
         n_cmp++;
         if (mst_gnt_o !== 1'b1) begin
            n_mis++; $display("FAIL dma_gnt_%0d: got %b want 1", k, mst_gnt_o);
         end
      end
      for (int k = 0; k < 2; k++) begin
         step(); drive_req(32'h0000_2400, 5'd4, 1'b1); slv_gnt_i[9] = 1'b1;
         @(negedge clk_i);
         n_cmp++;
         if ({mst_gnt_o, slv_req_o} !== {1'b0, 11'h000}) begin
            n_mis++; $display("FAIL dma_full_stall: got gnt=%b req=%h want gnt=0 req=000", mst_gnt_o, slv_req_o);
         end
      end
      step(); drive_req(32'h0000_2400, 5'd4, 1'b1); slv_gnt_i[9] = 1'b1; slave_resp(9, 32'hD0, 5'd0, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_gnt_o, mst_r_valid_o, mst_r_id_o} !== {1'b1, 1'b1, 5'd0}) begin
         n_mis++; $display("FAIL dma_free_slot: got gnt=%b v=%b id=%h want 1 1 00", mst_gnt_o, mst_r_valid_o, mst_r_id_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step(); slave_resp(9, 32'hD0 + 32'(k), 5'(k), 1'b0);
         @(negedge clk_i);
         n_cmp++;
         if ({mst_r_valid_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 32'hD0 + 32'(k), 5'(k)}) begin
            n_mis++; $display("FAIL dma_drain_%0d: got v=%b rdata=%h id=%h", k, mst_r_valid_o, mst_r_rdata_o, mst_r_id_o);
         end
      end
   endtask

   task automatic test_target_switch();
      step(); drive_req(32'h0000_0000, 5'd3, 1'b0); slv_gnt_i[0] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (mst_gnt_o !== 1'b1) begin
         n_mis++; $display("FAIL eoc_gnt: got %b want 1", mst_gnt_o);
      end
      for (int k = 0; k < 2; k++) begin
         step(); drive_req(32'h0000_0800, 5'd4, 1'b1); slv_gnt_i = 11'h005;
         @(negedge clk_i);
         n_cmp++;
         if ({mst_gnt_o, slv_req_o} !== {1'b0, 11'h000}) begin
            n_mis++; $display("FAIL switch_stall_%0d: got gnt=%b req=%h want 0 000", k, mst_gnt_o, slv_req_o);
         end
      end
      step(); drive_req(32'h0000_0800, 5'd4, 1'b1); slv_gnt_i = 11'h005; slave_resp(0, 32'h0, 5'd3, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_gnt_o, slv_req_o, mst_r_valid_o, mst_r_id_o} !== {1'b1, 11'h004, 1'b1, 5'd3}) begin
         n_mis++; $display("FAIL switch_same_cycle: got gnt=%b req=%h v=%b id=%h want 1 004 1 03",
                           mst_gnt_o, slv_req_o, mst_r_valid_o, mst_r_id_o);
      end
      step(); slave_resp(2, 32'hE2, 5'd4, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 32'hE2, 5'd4}) begin
         n_mis++; $display("FAIL switch_new_resp: got v=%b rdata=%h id=%h want 1 e2 04", mst_r_valid_o, mst_r_rdata_o, mst_r_id_o);
      end
   endtask

   task automatic test_unmapped();
      step(); drive_req(32'h0000_0C00, 5'd7, 1'b1); slv_gnt_i = '1;
      @(negedge clk_i);
`ifdef PERIPH_ROUTER_ERR_RESP_EN
      n_cmp++;
      if ({slv_req_o, mst_gnt_o} !== {11'h000, 1'b1}) begin
         n_mis++; $display("FAIL unmapped_req: got req=%h gnt=%b want 000 1", slv_req_o, mst_gnt_o);
      end
      step();
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 1'b1, 32'hBADA_CCE5, 5'd7}) begin
         n_mis++; $display("FAIL unmapped_err: got v=%b opc=%b rdata=%h id=%h want 1 1 badacce5 07",
                           mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o);
      end
      step();
      @(negedge clk_i);
      n_cmp++;
      if (mst_r_valid_o !== 1'b0) begin
         n_mis++; $display("FAIL unmapped_single: got v=%b want 0", mst_r_valid_o);
      end
`else
      n_cmp++;
      if ({slv_req_o, mst_gnt_o} !== {11'h400, 1'b1}) begin
         n_mis++; $display("FAIL unmapped_ext: got req=%h gnt=%b want 400 1", slv_req_o, mst_gnt_o);
      end
      step(); slave_resp(10, 32'hE10, 5'd7, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 1'b0, 32'hE10, 5'd7}) begin
         n_mis++; $display("FAIL unmapped_ext_resp: got v=%b opc=%b rdata=%h id=%h want 1 0 e10 07",
                           mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o);
      end
`endif
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k <= 20; k++) begin
         step();
         if (k < 20) begin
            drive_req(32'h0000_0400, 5'(k), 1'b1); slv_gnt_i[1] = 1'b1;
         end
         if (k > 0) slave_resp(1, 32'hB000 + 32'(k - 1), 5'(k - 1), 1'b0);
         @(negedge clk_i);
         if (k < 20) begin
            n_cmp++;
            if (mst_gnt_o !== 1'b1) begin
               n_mis++; $display("FAIL stream_gnt_%0d: got %b want 1", k, mst_gnt_o);
            end
         end
         if (k > 0) begin
            n_cmp++;
            if ({mst_r_valid_o, mst_r_rdata_o, mst_r_id_o} !== {1'b1, 32'hB000 + 32'(k - 1), 5'(k - 1)}) begin
               n_mis++; $display("FAIL stream_resp_%0d: got v=%b rdata=%h id=%h", k - 1, mst_r_valid_o, mst_r_rdata_o, mst_r_id_o);
            end
         end
      end
      step(); drive_req(32'h0000_0800, 5'd9, 1'b1); slv_gnt_i[2] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (mst_gnt_o !== 1'b1) begin
         n_mis++; $display("FAIL stream_cnt_zero: got gnt=%b want 1", mst_gnt_o);
      end
      step(); slave_resp(2, 32'h9, 5'd9, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_id_o} !== {1'b1, 5'd9}) begin
         n_mis++; $display("FAIL stream_tail_resp: got v=%b id=%h want 1 09", mst_r_valid_o, mst_r_id_o);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         step(); drive_req(32'h0000_2400, 5'(k), 1'b1); slv_gnt_i[9] = 1'b1;
         @(negedge clk_i);
         n_cmp++;
         if (mst_gnt_o !== 1'b1) begin
            n_mis++; $display("FAIL rstmid_gnt_%0d: got %b want 1", k, mst_gnt_o);
         end
      end
      step(); rst_i = 1'b1;
      step();
      @(negedge clk_i);
      n_cmp++;
      if ({mst_gnt_o, mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o, slv_req_o} !== '0) begin
         n_mis++; $display("FAIL rstmid_outputs: got gnt=%b v=%b req=%h want all zero", mst_gnt_o, mst_r_valid_o, slv_req_o);
      end
      step(); rst_i = 1'b0; slave_resp(9, 32'hDEAD, 5'd0, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if (mst_r_valid_o !== 1'b0) begin
         n_mis++; $display("FAIL rstmid_late_resp: got v=%b want 0", mst_r_valid_o);
      end
      step(); drive_req(32'h0000_0800, 5'd1, 1'b1); slv_gnt_i[2] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (mst_gnt_o !== 1'b1) begin
         n_mis++; $display("FAIL rstmid_cnt_zero: got gnt=%b want 1", mst_gnt_o);
      end
      step(); slave_resp(2, 32'h77, 5'd1, 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if ({mst_r_valid_o, mst_r_rdata_o} !== {1'b1, 32'h77}) begin
         n_mis++; $display("FAIL rstmid_after_resp: got v=%b rdata=%h want 1 77", mst_r_valid_o, mst_r_rdata_o);
      end
   endtask

   task automatic test_random();
      txn_t oq[$];
      txn_t e;
      int last_t;
      last_t = 1;
      for (int c = 0; c < 900; c++) begin
         int t, route, eff, s;
         bit resp_m, stall_m, exp_gnt;
         logic [NB-1:0] exp_req, g;
         logic [AW-1:0] a;
         step();
         t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : last_t;
         last_t = t;
         a = $urandom;
         a[13:10] = 4'(t);
         mst_req_i = (c < 800) && ($urandom_range(0, 3) != 0);
         mst_add_i = a;
         mst_id_i = 5'($urandom);
         mst_wen_i = 1'($urandom);
         mst_wdata_i = $urandom;
         mst_be_i = 4'($urandom);
         g = 11'($urandom | $urandom);
         slv_gnt_i = g;
         resp_m = 1'b0;
         if (oq.size() > 0) begin
            if (oq[0].tgt == 15) begin
               resp_m = (c == oq[0].due);
            end else if (c >= oq[0].due && $urandom_range(0, 3) != 0) begin
               resp_m = 1'b1;
               slave_resp(oq[0].tgt, oq[0].data, oq[0].id, oq[0].opc);
            end
         end
         s = $urandom_range(0, NB - 1);
         if ((oq.size() == 0 || s != oq[0].tgt) && $urandom_range(0, 1) == 1)
            slave_resp(s, $urandom, 5'($urandom), 1'($urandom));
         route = is_mapped(t) ? t : (ERR_EN ? 15 : 10);
         eff = oq.size() - int'(resp_m);
         stall_m = (eff == MAXO) || (eff != 0 && route != oq[0].tgt);
         exp_gnt = !stall_m && ((route == 15) ? mst_req_i : g[route]);
         exp_req = '0;
         if (mst_req_i && !stall_m && route != 15) exp_req[route] = 1'b1;
         @(negedge clk_i);
         n_cmp++;
         if (mst_r_valid_o !== resp_m) begin
            n_mis++; $display("FAIL rand_rvalid c=%0d: got %b want %b", c, mst_r_valid_o, resp_m);
         end
         n_cmp++;
         if ({mst_gnt_o, slv_req_o} !== {exp_gnt, exp_req}) begin
            n_mis++; $display("FAIL rand_gnt_req c=%0d tgt=%0d: got gnt=%b req=%h want gnt=%b req=%h",
                              c, t, mst_gnt_o, slv_req_o, exp_gnt, exp_req);
         end
         if (resp_m) begin
            n_cmp++;
            if ({mst_r_opc_o, mst_r_rdata_o, mst_r_id_o} !== {oq[0].opc, oq[0].data, oq[0].id}) begin
               n_mis++; $display("FAIL rand_resp c=%0d: got opc=%b rdata=%h id=%h want opc=%b rdata=%h id=%h",
                                 c, mst_r_opc_o, mst_r_rdata_o, mst_r_id_o, oq[0].opc, oq[0].data, oq[0].id);
            end
            void'(oq.pop_front());
         end
         if (mst_req_i && exp_gnt) begin
            e.tgt = route;
            e.id = mst_id_i;
            e.data = (route == 15) ? 32'hBADA_CCE5 : $urandom;
            e.opc = (route == 15) ? 1'b1 : 1'($urandom);
            e.due = c + ((route == 15) ? 1 : int'($urandom_range(1, 3)));
            oq.push_back(e);
         end
      end
      n_cmp++;
      if (oq.size() != 0) begin
         n_mis++; $display("FAIL rand_drain: got %0d outstanding want 0", oq.size());
      end
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      test_reset();
      test_single_read();
      test_outstanding_limit();
      test_target_switch();
      test_unmapped();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
